// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control unit: field encodings, ALU
// command codes, FSM states and the packed control word handed to ID/EX.
package ctrl_pkg;

    localparam logic [1:0] MODE_ALU    = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_BLOCK  = 2'b11;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SORT = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADC  = 4'b0101;
    localparam logic [3:0] OP_SBC  = 4'b0110;
    localparam logic [3:0] OP_TST  = 4'b1000;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_MVN  = 4'b1111;
    localparam logic [3:0] OP_LDST = 4'b0100;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_t;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s_out;
        logic [3:0] exe_cmd;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    // Single load (s=1) or store (s=0) micro-op; shared by Mode 01 and every block beat.
    function automatic ctrl_word_t mem_word(input logic s);
        ctrl_word_t w;
        w          = CTRL_NOP;
        w.exe_cmd  = EXE_ADD;
        w.wb_en    = s;
        w.mem_r_en = s;
        w.mem_w_en = !s;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of {mode, opcode, s} into a control word, an illegal
// flag and the block-transfer beat count. Illegal encodings yield an all-zero word.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MAX_BEATS = 16
) (
    input  logic [1:0] mode_i,
    input  logic [3:0] opcode_i,
    input  logic       s_i,
    output ctrl_word_t word_o,
    output logic       illegal_o,
    output logic [3:0] beats_m1_o,
    output logic       multi_beat_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        word_o       = CTRL_NOP;
        illegal_o    = 1'b0;
        beats_m1_o   = '0;
        multi_beat_o = 1'b0;

        case (mode_i)
            MODE_ALU: begin
                word_o.wb_en = 1'b1;
                word_o.s_out = s_i;
                case (opcode_i)
                    OP_MOV:  word_o.exe_cmd = EXE_MOV;
                    OP_MVN:  word_o.exe_cmd = EXE_MVN;
                    OP_ADD:  word_o.exe_cmd = EXE_ADD;
                    OP_ADC:  word_o.exe_cmd = EXE_ADC;
                    OP_SUB:  word_o.exe_cmd = EXE_SUB;
                    OP_SBC:  word_o.exe_cmd = EXE_SBC;
                    OP_AND:  word_o.exe_cmd = EXE_AND;
                    OP_ORR:  word_o.exe_cmd = EXE_ORR;
                    OP_EOR:  word_o.exe_cmd = EXE_EOR;
                    OP_SORT: word_o.exe_cmd = EXE_SUB;
                    // Compare/test only set flags, so they are meaningless without S.
                    OP_CMP: begin
                        word_o.wb_en   = 1'b0;
                        word_o.exe_cmd = EXE_SUB;
                        illegal_o      = !s_i;
                    end
                    OP_TST: begin
                        word_o.wb_en   = 1'b0;
                        word_o.exe_cmd = EXE_AND;
                        illegal_o      = !s_i;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            MODE_MEM: begin
                if (opcode_i == OP_LDST) begin
                    word_o = mem_word(s_i);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            MODE_BRANCH: begin
                word_o.b = 1'b1;
            end
            default: begin
                word_o = mem_word(s_i);
                if (int'({1'b0, opcode_i}) >= MAX_BEATS) begin
                    illegal_o = 1'b1;
                end else begin
                    beats_m1_o   = opcode_i;
                    multi_beat_o = (opcode_i != 4'd0);
                end
            end
        endcase

        if (illegal_o) begin
            word_o       = CTRL_NOP;
            beats_m1_o   = '0;
            multi_beat_o = 1'b0;
        end
    end

endmodule

// File: rtl/control_unit_seq.sv
// Registered ID-stage control unit: decodes one instruction per cycle and
// expands Mode-11 block transfers into one memory micro-op per cycle.
module control_unit_seq
    import ctrl_pkg::*;
#(
    parameter int EXE_CMD_W = 4,
    parameter int MAX_BEATS = 16,
    parameter int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic [3:0]           opcode,
    input  logic                 s,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic                 wb_en,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic                 b,
    output logic                 s_out,
    output logic [EXE_CMD_W-1:0] exe_cmd,
    output logic [BEAT_W-1:0]    beat_idx,
    output logic                 last_beat,
    output logic                 illegal
);

    ctrl_word_t        dec_word;
    logic              dec_illegal;
    logic [3:0]        dec_beats_m1;
    logic              dec_multi;

    state_t            state_q, state_d;
    ctrl_word_t        word_q, word_d;
    logic              out_valid_q, out_valid_d;
    logic              last_q, last_d;
    logic              illegal_q, illegal_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] blk_last_q, blk_last_d;
    logic              blk_s_q, blk_s_d;
    logic              accept;

    ctrl_decode #(
        .MAX_BEATS (MAX_BEATS)
    ) u_decode (
        .mode_i       (mode),
        .opcode_i     (opcode),
        .s_i          (s),
        .word_o       (dec_word),
        .illegal_o    (dec_illegal),
        .beats_m1_o   (dec_beats_m1),
        .multi_beat_o (dec_multi)
    );

    // Ready never looks at in_valid, so upstream can rely on it without a loop.
    assign in_ready = (state_q == IDLE) && !stall && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = CTRL_NOP;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        illegal_d   = 1'b0;
        beat_d      = '0;
        blk_last_d  = blk_last_q;
        blk_s_d     = blk_s_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    word_d      = dec_word;
                    illegal_d   = dec_illegal;
                    if (dec_multi) begin
                        state_d    = BLOCK;
                        blk_last_d = BEAT_W'(dec_beats_m1);
                        blk_s_d    = s;
                    end else begin
                        last_d = 1'b1;
                    end
                end
            end
            BLOCK: begin
                out_valid_d = 1'b1;
                word_d      = mem_word(blk_s_q);
                beat_d      = beat_q + BEAT_W'(1);
                last_d      = (beat_d == blk_last_q);
                if (last_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset and flush both clear the pipeline slot; stall freezes every register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q     <= IDLE;
            word_q      <= CTRL_NOP;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            illegal_q   <= 1'b0;
            beat_q      <= '0;
            blk_last_q  <= '0;
            blk_s_q     <= 1'b0;
        end else if (!stall) begin
            state_q     <= state_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            illegal_q   <= illegal_d;
            beat_q      <= beat_d;
            blk_last_q  <= blk_last_d;
            blk_s_q     <= blk_s_d;
        end
    end

    assign out_valid = out_valid_q;
    assign wb_en     = word_q.wb_en;
    assign mem_r_en  = word_q.mem_r_en;
    assign mem_w_en  = word_q.mem_w_en;
    assign b         = word_q.b;
    assign s_out     = word_q.s_out;
    assign exe_cmd   = EXE_CMD_W'(word_q.exe_cmd);
    assign beat_idx  = beat_q;
    assign last_beat = last_q;
    assign illegal   = illegal_q;

endmodule
